mod997_mult_seq: RTL and testbench
==================================

MOD997_MULT_SEQ -- requirements
Module: mod997_mult_seq

Interface
REQ-001 The block SHALL have no parameters; all constants SHALL come from mod997_pkg.
REQ-002 The block SHALL have exactly one clock; its reset SHALL be asynchronous and active-low, with ports named as follows.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  10  operand A, any value 0..1023.
REQ-008 b  input  10  operand B, any value 0..1023.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  10  (a*b) mod 997, range 0..996.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL use a four-state FSM: IDLE, MUL, RED, DONE.
REQ-014 in_ready SHALL equal (state==IDLE).
REQ-015 Acceptance SHALL occur on a rising edge with in_valid&in_ready; a and b SHALL be registered, zero-extended to 12 bits (four 3-bit digits), the accumulator cleared, the digit counter cleared, and state set to MUL.
REQ-016 In MUL, the block SHALL make one 3x3 digit product per cycle, for i,j in 0..3, with j incrementing fastest.
REQ-017 In MUL, each digit product SHALL be added to the 21-bit accumulator shifted left by 3*(i+j).
REQ-018 MUL SHALL last exactly 16 cycles, then the block SHALL go to RED with the reduction step index k=10.
REQ-019 In RED, each cycle: if acc >= (997<<k), then acc = acc-(997<<k); then k decrements. RED SHALL last exactly 11 cycles (k=10..0), then the block SHALL go to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and result SHALL equal acc[9:0].
REQ-021 out_valid SHALL first be high at the 27th rising edge after the acceptance edge.
REQ-022 result and out_valid SHALL hold stable while out_valid&!out_ready.
REQ-023 On out_valid&out_ready the block SHALL return to IDLE; in_ready SHALL be high on the following cycle, so there is no back-to-back overlap.
REQ-024 in_valid SHALL be ignored outside IDLE; a and b SHALL be sampled only at acceptance.
REQ-025 The accumulator SHALL be 21 bits wide; the maximum product 1023^2=1046529 SHALL NOT overflow it.
REQ-026 Outside DONE, out_valid SHALL be 0 and result SHALL be 0.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, acc=0, counters=0, registered operands=0, out_valid=0, result=0, busy=0, in_ready=1.
REQ-028 Reset asserted in MUL, RED or DONE SHALL abort the operation with no output produced; the first accept after reset release SHALL compute a fresh result.

Structure
REQ-029 mod997_pkg SHALL hold MODULUS=997, DIGIT_W=3, N_DIGITS=4, ACC_W=21, RED_STEPS=11, and the FSM state enum.
REQ-030 The 3x3 digit product SHALL be one combinational sub-module, mod997_digit_mult (two 3-bit inputs, one 6-bit output), instantiated once.
REQ-031 All other logic (FSM, digit selection, accumulate, reduce) SHALL reside in mod997_mult_seq.

Verification
REQ-032 The bench SHALL cover: a=996, b=996 -> result=1, out_valid 27 edges after accept.
REQ-033 The bench SHALL cover: a=123, b=456 -> result=256; a=500, b=2 -> result=3; a=0, b=777 -> result=0.
REQ-034 The bench SHALL cover: a=1023, b=1023 -> result=676, with no accumulator overflow.
REQ-035 The bench SHALL cover: result ready, out_ready low 5 cycles -> result/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 The bench SHALL cover: rst_n pulsed low in MUL cycle 8 -> outputs at reset values immediately; next accept a=2, b=3 -> result=6.
REQ-037 The bench SHALL cover: in_valid toggled with new operands during MUL/RED -> ignored; result matches the originally accepted pair.

Source files
------------

// File: rtl/mod997_pkg.sv
// Shared constants and FSM state type for the sequential
// (a*b) mod 997 multiplier.
package mod997_pkg;

    localparam int MODULUS   = 997;
    localparam int DIGIT_W   = 3;
    localparam int N_DIGITS  = 4;
    localparam int ACC_W     = 21;
    localparam int RED_STEPS = 11;

    localparam int IN_W   = 10;
    localparam int OP_W   = DIGIT_W * N_DIGITS;
    localparam int PROD_W = 2 * DIGIT_W;
    localparam int CNT_W  = 4;
    localparam int K_W    = 4;

    localparam int LAST_PAIR = N_DIGITS * N_DIGITS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod997_digit_mult.sv
// Combinational 3x3-bit digit product, one per MUL cycle.
// Pure unsigned multiply into a 6-bit result.
module mod997_digit_mult
    import mod997_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [PROD_W-1:0]  p
);

    assign p = PROD_W'(x) * PROD_W'(y);

endmodule

// File: rtl/mod997_mult_seq.sv
// Sequential (a*b) mod 997: 16 digit-product cycles, then
// 11 shift-subtract reduction cycles, then result hold.
module mod997_mult_seq
    import mod997_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] a,
    input  logic [IN_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IN_W-1:0] result,
    output logic            busy
);

    state_t state_q;
    state_t state_d;

    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [K_W-1:0]     k_q;

    logic [1:0]         dig_i;
    logic [1:0]         dig_j;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   red_sub;
    logic               accept;
    logic               last_pair;

    assign accept    = in_valid & in_ready;
    assign last_pair = (cnt_q == CNT_W'(LAST_PAIR));

    // j is the low counter field so it advances fastest
    assign dig_i = cnt_q[3:2];
    assign dig_j = cnt_q[1:0];
    assign a_dig = a_q[DIGIT_W*int'(dig_i) +: DIGIT_W];
    assign b_dig = b_q[DIGIT_W*int'(dig_j) +: DIGIT_W];

    mod997_digit_mult u_dmul (
        .x (a_dig),
        .y (b_dig),
        .p (prod)
    );

    assign term    = ACC_W'(prod) << (DIGIT_W * (int'(dig_i) + int'(dig_j)));
    assign red_sub = ACC_W'(MODULUS) << k_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/result outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        result    = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = MUL;
            end
            MUL: begin
                if (last_pair) state_d = RED;
            end
            RED: begin
                if (k_q == '0) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                result    = acc_q[IN_W-1:0];
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    // Operand capture, accumulate and shift-subtract reduction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= OP_W'(a);
                        b_q   <= OP_W'(b);
                        acc_q <= '0;
                        cnt_q <= '0;
                        k_q   <= '0;
                    end
                end
                MUL: begin
                    acc_q <= acc_q + term;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_pair) k_q <= K_W'(RED_STEPS - 1);
                end
                RED: begin
                    if (acc_q >= red_sub) acc_q <= acc_q - red_sub;
                    if (k_q != '0) k_q <= k_q - 1'b1;
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod997_mult_seq.sv
// Self-checking bench for mod997_mult_seq: vector table,
// random operands vs. plain-arithmetic model, corner sequences.
module tb_mod997_mult_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] a = '0;
    logic [9:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] result;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[9];

    mod997_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int model(input int x, input int y);
        return (x * y) % 997;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept one pair, then wait for out_valid (out_ready held low).
    task automatic do_op(input logic [9:0] ta, input logic [9:0] tb_,
                         input bit noise,
                         output logic [9:0] res, output int lat);
        int guard;
        guard = 0;
        lat = 0;
        res = '0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_in_ready", int'(in_ready), 1);
        @(negedge clk);
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("in_ready_after_accept", int'(in_ready), 0);
        while (lat < 60) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a = 10'($urandom);
                b = 10'($urandom);
            end
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check("out_valid_seen", int'(out_valid), 1);
        res = result;
    endtask

    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_result", int'(result), 0);
    endtask

    initial begin
        logic [9:0] res;
        logic [9:0] ra;
        logic [9:0] rb;
        int lat;

        vecs[0] = '{10'd996,  10'd996,  10'd1};
        vecs[1] = '{10'd123,  10'd456,  10'd256};
        vecs[2] = '{10'd500,  10'd2,    10'd3};
        vecs[3] = '{10'd0,    10'd777,  10'd0};
        vecs[4] = '{10'd1023, 10'd1023, 10'd676};
        vecs[5] = '{10'd0,    10'd0,    10'd0};
        vecs[6] = '{10'd1,    10'd996,  10'd996};
        vecs[7] = '{10'd997,  10'd997,  10'd0};
        vecs[8] = '{10'd1023, 10'd1,    10'd26};

        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, res, lat);
            check($sformatf("vec%0d_result", i), int'(res), int'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), lat, 27);
            release_op();
        end

        for (int i = 0; i < 12; i++) begin
            ra = 10'($urandom);
            rb = 10'($urandom);
            do_op(ra, rb, 1'b0, res, lat);
            check($sformatf("rand%0d_%0dx%0d", i, ra, rb),
                  int'(res), model(int'(ra), int'(rb)));
            release_op();
        end

        // Backpressure: result held while out_ready stays low
        do_op(10'd123, 10'd456, 1'b0, res, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_result", int'(result), 256);
            check("hold_in_ready", int'(in_ready), 0);
        end
        release_op();

        // Operand/in_valid activity while busy must not disturb the op
        for (int i = 0; i < 3; i++) begin
            ra = 10'($urandom);
            rb = 10'($urandom);
            do_op(ra, rb, 1'b1, res, lat);
            check($sformatf("noise%0d_result", i),
                  int'(res), model(int'(ra), int'(rb)));
            check($sformatf("noise%0d_latency", i), lat, 27);
            release_op();
        end

        // Reset mid-MUL aborts; next op computes fresh
        @(negedge clk);
        a = 10'd1000;
        b = 10'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_result", int'(result), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(10'd2, 10'd3, 1'b0, res, lat);
        check("post_rst_result", int'(res), 6);
        check("post_rst_latency", lat, 27);
        release_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
